// File: rtl/if_fetch_queue_pkg.sv
// Shared constants and types for the decoupled instruction fetch stage.
// Holds the IF->ID bundle layout and the fetch FSM encoding.
package if_fetch_queue_pkg;

    localparam int          TO_ID_DATA_WIDTH = 65;
    localparam int          BR_DATA_WIDTH    = 33;
    localparam logic [31:0] PC_RESET_DEF     = 32'h1c000000;

    localparam int ADEF_BIT = 0;
    localparam int INST_LSB = 1;
    localparam int INST_MSB = 32;
    localparam int PC_LSB   = 33;
    localparam int PC_MSB   = 64;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } fetch_st_t;

    function automatic logic [TO_ID_DATA_WIDTH-1:0] pack_to_id(
        input logic [31:0] pc,
        input logic [31:0] inst,
        input logic        adef
    );
        logic [TO_ID_DATA_WIDTH-1:0] d;
        d                    = '0;
        d[PC_MSB:PC_LSB]     = pc;
        d[INST_MSB:INST_LSB] = inst;
        d[ADEF_BIT]          = adef;
        return d;
    endfunction

endpackage

// File: rtl/if_resv_queue.sv
// Reservation FIFO: slots are reserved at request time and filled in order
// when responses arrive, so the head may be waiting on the bus.
module if_resv_queue
    import if_fetch_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        flush_i,
    input  logic                        rsv_i,
    input  logic [31:0]                 rsv_pc_i,
    input  logic                        adef_i,
    input  logic [31:0]                 adef_pc_i,
    input  logic                        fill_i,
    input  logic [31:0]                 fill_inst_i,
    input  logic                        pop_i,
    output logic                        head_filled_o,
    output logic [TO_ID_DATA_WIDTH-1:0] head_data_o,
    output logic [CNT_W-1:0]            count_o,
    output logic [CNT_W-1:0]            pend_o
);

    localparam int PW = $clog2(DEPTH);

    logic [31:0]      pc_q   [DEPTH];
    logic [31:0]      inst_q [DEPTH];
    logic [DEPTH-1:0] adef_q;
    logic [DEPTH-1:0] filled_q;

    logic [PW-1:0]    head_q, head_d;
    logic [PW-1:0]    tail_q, tail_d;
    logic [PW-1:0]    fptr_q, fptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] pend_q, pend_d;

    logic push;
    logic fill_ok;

    assign push    = rsv_i | adef_i;
    assign fill_ok = fill_i & (pend_q != '0);

    // fptr tracks the oldest unfilled slot; with nothing pending it parks
    // at the tail so a filled ADEF slot is never taken for a response.
    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        fptr_d = fptr_q;
        cnt_d  = cnt_q;
        pend_d = pend_q;
        if (flush_i) begin
            head_d = tail_q;
            fptr_d = tail_q;
            cnt_d  = '0;
            pend_d = '0;
        end else begin
            if (push)
                tail_d = tail_q + PW'(1);
            if (pop_i)
                head_d = head_q + PW'(1);
            cnt_d  = cnt_q + CNT_W'(push) - CNT_W'(pop_i);
            pend_d = pend_q + CNT_W'(rsv_i) - CNT_W'(fill_ok);
            if (pend_d == '0)
                fptr_d = tail_d;
            else
                fptr_d = fptr_q + PW'(fill_ok);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head_q <= '0;
            tail_q <= '0;
            fptr_q <= '0;
            cnt_q  <= '0;
            pend_q <= '0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            fptr_q <= fptr_d;
            cnt_q  <= cnt_d;
            pend_q <= pend_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                pc_q[i]   <= '0;
                inst_q[i] <= '0;
            end
            adef_q   <= '0;
            filled_q <= '0;
        end else if (!flush_i) begin
            if (rsv_i) begin
                pc_q[tail_q]     <= rsv_pc_i;
                inst_q[tail_q]   <= '0;
                adef_q[tail_q]   <= 1'b0;
                filled_q[tail_q] <= 1'b0;
            end else if (adef_i) begin
                pc_q[tail_q]     <= adef_pc_i;
                inst_q[tail_q]   <= '0;
                adef_q[tail_q]   <= 1'b1;
                filled_q[tail_q] <= 1'b1;
            end
            if (fill_ok) begin
                inst_q[fptr_q]   <= fill_inst_i;
                filled_q[fptr_q] <= 1'b1;
            end
        end
    end

    assign head_filled_o = (cnt_q != '0) & filled_q[head_q];
    assign head_data_o   = pack_to_id(pc_q[head_q], inst_q[head_q],
                                      adef_q[head_q]);
    assign count_o       = cnt_q;
    assign pend_o        = pend_q;

endmodule

// File: rtl/if_fetch_queue.sv
// Decoupled IF stage: issues fetches ahead of ID into a reservation queue
// and cancels stale responses after a redirect.
module if_fetch_queue
    import if_fetch_queue_pkg::*;
#(
    parameter logic [31:0] PC_RESET = PC_RESET_DEF,
    parameter int          FQ_DEPTH = 4,
    parameter int          CNT_W    = $clog2(FQ_DEPTH) + 1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        ex_redirect,
    input  logic [31:0]                 ex_entry,
    input  logic                        br_taken,
    input  logic [31:0]                 br_target,
    output logic                        inst_req,
    output logic                        inst_wr,
    output logic [1:0]                  inst_size,
    output logic [31:0]                 inst_addr,
    output logic [31:0]                 inst_wdata,
    input  logic                        inst_addr_ok,
    input  logic                        inst_data_ok,
    input  logic [31:0]                 inst_rdata,
    input  logic                        id_allow_in,
    output logic                        if_to_id_valid,
    output logic [TO_ID_DATA_WIDTH-1:0] if_to_id_data
);

    fetch_st_t        fsm_q;
    logic [31:0]      fetch_pc_q;
    logic             hold_q;
    logic [31:0]      hold_addr_q;
    logic             stale_q;
    logic [CNT_W-1:0] cancel_q, cancel_d;

    logic [BR_DATA_WIDTH-1:0] br_bus;
    logic             redirect;
    logic [31:0]      target;
    logic             occ_ok;
    logic             can_issue;
    logic             accept;
    logic             old_acc;
    logic             new_acc;
    logic             fill;
    logic             drop;
    logic             adef_go;
    logic             pop;

    logic                        q_head_filled;
    logic [TO_ID_DATA_WIDTH-1:0] q_head_data;
    logic [CNT_W-1:0]            q_cnt;
    logic [CNT_W-1:0]            q_pend;

    assign br_bus   = {br_taken, br_target};
    assign redirect = ex_redirect | br_bus[BR_DATA_WIDTH-1];
    assign target   = ex_redirect ? ex_entry : br_bus[31:0];

    assign occ_ok    = q_cnt < CNT_W'(FQ_DEPTH);
    assign can_issue = (fsm_q == ST_RUN) & (fetch_pc_q[1:0] == 2'b00)
                     & ~redirect & occ_ok
                     & (cancel_q < CNT_W'(FQ_DEPTH));

    assign inst_req   = ~reset & (hold_q | can_issue);
    assign inst_addr  = hold_q ? hold_addr_q : fetch_pc_q;
    assign inst_wr    = 1'b0;
    assign inst_size  = 2'b10;
    assign inst_wdata = '0;

    // A request accepted in or after a redirect belongs to the old path.
    assign accept  = inst_req & inst_addr_ok;
    assign old_acc = accept & (stale_q | redirect);
    assign new_acc = accept & ~old_acc;

    assign fill = inst_data_ok & (cancel_q == '0) & (q_pend != '0);
    assign drop = inst_data_ok & (cancel_q != '0);

    assign adef_go = ~reset & (fsm_q == ST_RUN)
                   & (fetch_pc_q[1:0] != 2'b00) & ~redirect & occ_ok;

    assign pop = q_head_filled & id_allow_in;

    always_comb begin
        cancel_d = cancel_q - CNT_W'(drop);
        if (redirect)
            cancel_d = cancel_d + q_pend - CNT_W'(fill) + CNT_W'(accept);
        else
            cancel_d = cancel_d + CNT_W'(accept & stale_q);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fsm_q       <= ST_RUN;
            fetch_pc_q  <= PC_RESET;
            hold_q      <= 1'b0;
            hold_addr_q <= '0;
            stale_q     <= 1'b0;
            cancel_q    <= '0;
        end else begin
            cancel_q <= cancel_d;
            hold_q   <= inst_req & ~inst_addr_ok;
            stale_q  <= inst_req & ~inst_addr_ok & (stale_q | redirect);
            if (inst_req & ~hold_q)
                hold_addr_q <= fetch_pc_q;
            if (redirect) begin
                fetch_pc_q <= target;
                fsm_q      <= ST_RUN;
            end else begin
                if (new_acc)
                    fetch_pc_q <= fetch_pc_q + 32'd4;
                unique case (fsm_q)
                    ST_RUN:  if (adef_go) fsm_q <= ST_HALT;
                    ST_HALT: fsm_q <= ST_HALT;
                    default: fsm_q <= ST_RUN;
                endcase
            end
        end
    end

    if_resv_queue #(
        .DEPTH (FQ_DEPTH),
        .CNT_W (CNT_W)
    ) u_queue (
        .clk           (clk),
        .reset         (reset),
        .flush_i       (redirect),
        .rsv_i         (new_acc),
        .rsv_pc_i      (inst_addr),
        .adef_i        (adef_go),
        .adef_pc_i     (fetch_pc_q),
        .fill_i        (fill),
        .fill_inst_i   (inst_rdata),
        .pop_i         (pop),
        .head_filled_o (q_head_filled),
        .head_data_o   (q_head_data),
        .count_o       (q_cnt),
        .pend_o        (q_pend)
    );

    assign if_to_id_valid = q_head_filled;
    assign if_to_id_data  = q_head_data;

endmodule

// File: tb/tb_if_fetch_queue.sv
// Directed bench for if_fetch_queue with an in-order bus model and a
// scoreboard of expected IF->ID bundles.
module tb_if_fetch_queue;

    localparam logic [31:0] K   = 32'h5a5a0000;
    localparam logic [31:0] PCR = 32'h1c000000;

    logic        clk;
    logic        reset;
    logic        ex_redirect;
    logic [31:0] ex_entry;
    logic        br_taken;
    logic [31:0] br_target;
    logic        inst_req;
    logic        inst_wr;
    logic [1:0]  inst_size;
    logic [31:0] inst_addr;
    logic [31:0] inst_wdata;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;
    logic        id_allow_in;
    logic        if_to_id_valid;
    logic [64:0] if_to_id_data;

    if_fetch_queue dut (
        .clk            (clk),
        .reset          (reset),
        .ex_redirect    (ex_redirect),
        .ex_entry       (ex_entry),
        .br_taken       (br_taken),
        .br_target      (br_target),
        .inst_req       (inst_req),
        .inst_wr        (inst_wr),
        .inst_size      (inst_size),
        .inst_addr      (inst_addr),
        .inst_wdata     (inst_wdata),
        .inst_addr_ok   (inst_addr_ok),
        .inst_data_ok   (inst_data_ok),
        .inst_rdata     (inst_rdata),
        .id_allow_in    (id_allow_in),
        .if_to_id_valid (if_to_id_valid),
        .if_to_id_data  (if_to_id_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } resp_t;

    resp_t       resp_q[$];
    logic [64:0] exp_q[$];

    int          total = 0;
    int          bad = 0;
    int          now = 0;
    int          lat = 1;
    int          aok_delay = 0;
    int          req_age = 0;
    int          acc_cnt = 0;
    int          dlv_cnt = 0;
    logic [31:0] model_pc = PCR;
    logic [31:0] held_addr = '0;
    bit          stale_pending = 0;
    bit          watch = 0;
    logic [31:0] first_pc = '1;

    task automatic chk(input string tag, input logic [64:0] got,
                       input logic [64:0] want);
        total++;
        assert (got === want) else begin
            bad++;
            $error("FAIL %s: got %h want %h", tag, got, want);
        end
    endtask

    task automatic cycle();
        logic        redir;
        logic [31:0] tgt;
        logic [64:0] e;
        if (!reset && resp_q.size() > 0 && resp_q[0].due <= now) begin
            inst_data_ok = 1'b1;
            inst_rdata   = resp_q[0].addr ^ K;
        end else begin
            inst_data_ok = 1'b0;
            inst_rdata   = '0;
        end
        #1;
        inst_addr_ok = inst_req && (req_age >= aok_delay);
        #1;
        redir = ex_redirect | br_taken;
        tgt   = ex_redirect ? ex_entry : br_target;
        if (!reset && if_to_id_valid && id_allow_in) begin
            dlv_cnt++;
            if (watch) begin
                first_pc = if_to_id_data[64:33];
                watch    = 0;
            end
            total++;
            assert (exp_q.size() != 0) else begin
                bad++;
                $error("FAIL unexpected: got %h want none", if_to_id_data);
            end
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("deliver", if_to_id_data, e);
            end
        end
        if (!reset && inst_req && inst_addr_ok) begin
            acc_cnt++;
            resp_q.push_back('{inst_addr, now + lat});
            if (!redir) begin
                if (stale_pending) begin
                    chk("stale_addr", 65'(inst_addr), 65'(held_addr));
                    stale_pending = 0;
                end else begin
                    chk("req_addr", 65'(inst_addr), 65'(model_pc));
                    exp_q.push_back({model_pc, model_pc ^ K, 1'b0});
                    model_pc = model_pc + 32'd4;
                end
            end else begin
                stale_pending = 0;
            end
            req_age = 0;
        end else if (inst_req) begin
            req_age++;
        end else begin
            req_age = 0;
        end
        if (!reset && redir) begin
            exp_q.delete();
            if (inst_req && !inst_addr_ok) begin
                if (!stale_pending)
                    held_addr = model_pc;
                stale_pending = 1;
            end
            model_pc = tgt;
            if (tgt[1:0] != 2'b00)
                exp_q.push_back({tgt, 32'h0, 1'b1});
        end
        @(posedge clk);
        if (inst_data_ok)
            void'(resp_q.pop_front());
        now++;
        @(negedge clk);
    endtask

    initial begin
        bit          found;
        logic [31:0] h;
        reset        = 1'b1;
        ex_redirect  = 1'b0;
        ex_entry     = '0;
        br_taken     = 1'b0;
        br_target    = '0;
        inst_addr_ok = 1'b0;
        inst_data_ok = 1'b0;
        inst_rdata   = '0;
        id_allow_in  = 1'b0;
        @(negedge clk);
        repeat (2) cycle();
        chk("rst_req", 65'(inst_req), 65'(0));
        chk("rst_valid", 65'(if_to_id_valid), 65'(0));
        chk("rst_data", if_to_id_data, 65'(0));
        chk("const_size", 65'(inst_size), 65'(2));

        // Stalled ID: the queue fills to its depth and issue stops
        reset   = 1'b0;
        acc_cnt = 0;
        repeat (10) cycle();
        chk("stall_acc", 65'(acc_cnt), 65'(4));
        chk("stall_req", 65'(inst_req), 65'(0));
        chk("stall_valid", 65'(if_to_id_valid), 65'(1));

        id_allow_in = 1'b1;
        repeat (6) cycle();
        dlv_cnt = 0;
        repeat (8) cycle();
        chk("stream_rate", 65'(dlv_cnt), 65'(8));

        // Branch with three requests in flight at latency 3
        lat   = 3;
        found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (resp_q.size() == 3) found = 1;
            else cycle();
        end
        chk("inflight3", 65'(found), 65'(1));
        br_taken  = 1'b1;
        br_target = 32'h1c000100;
        cycle();
        br_taken = 1'b0;
        first_pc = '1;
        watch    = 1;
        repeat (14) cycle();
        chk("br_first", 65'(first_pc), 65'(32'h1c000100));

        // Exception wins over a simultaneous branch
        lat = 2;
        repeat (3) cycle();
        br_taken    = 1'b1;
        br_target   = 32'h1c000200;
        ex_redirect = 1'b1;
        ex_entry    = 32'h1c008000;
        cycle();
        br_taken    = 1'b0;
        ex_redirect = 1'b0;
        first_pc    = '1;
        watch       = 1;
        repeat (10) cycle();
        chk("ex_first", 65'(first_pc), 65'(32'h1c008000));

        // Redirect while a request waits for addr_ok
        lat       = 1;
        aok_delay = 4;
        found     = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (inst_req && req_age == 1) found = 1;
            else cycle();
        end
        chk("pend_found", 65'(found), 65'(1));
        h = model_pc;
        chk("pend_addr", 65'(inst_addr), 65'(h));
        br_taken  = 1'b1;
        br_target = 32'h1c000300;
        cycle();
        br_taken = 1'b0;
        first_pc = '1;
        watch    = 1;
        for (int i = 0; i < 6; i++) begin
            if (stale_pending) begin
                chk("hold_req", 65'(inst_req), 65'(1));
                chk("hold_addr", 65'(inst_addr), 65'(h));
            end
            cycle();
        end
        chk("stale_done", 65'(stale_pending), 65'(0));
        aok_delay = 0;
        repeat (12) cycle();
        chk("pend_first", 65'(first_pc), 65'(32'h1c000300));

        // Misaligned target: one ADEF entry, then halt until redirect
        repeat (4) cycle();
        br_taken  = 1'b1;
        br_target = 32'h1c000102;
        cycle();
        br_taken = 1'b0;
        first_pc = '1;
        watch    = 1;
        for (int i = 0; i < 6; i++) begin
            chk("halt_req", 65'(inst_req), 65'(0));
            cycle();
        end
        chk("adef_first", 65'(first_pc), 65'(32'h1c000102));
        ex_redirect = 1'b1;
        ex_entry    = 32'h1c001000;
        cycle();
        ex_redirect = 1'b0;
        first_pc    = '1;
        watch       = 1;
        repeat (10) cycle();
        chk("resume_first", 65'(first_pc), 65'(32'h1c001000));

        // Reset in the middle of streaming
        reset = 1'b1;
        resp_q.delete();
        exp_q.delete();
        stale_pending = 0;
        model_pc      = PCR;
        req_age       = 0;
        repeat (2) cycle();
        chk("rst2_req", 65'(inst_req), 65'(0));
        chk("rst2_valid", 65'(if_to_id_valid), 65'(0));
        reset    = 1'b0;
        first_pc = '1;
        watch    = 1;
        repeat (8) cycle();
        chk("rst2_first", 65'(first_pc), 65'(PCR));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
